// File: rtl/ramp_samp_adc.sv
// -----------------------------------------------------------------------------
// ramp_samp_adc
// -----------------------------------------------------------------------------
// Single-channel ramp-and-sample ADC sequencer. After `run` releases the
// ramp, the block counts clock cycles until the analog comparator trips. It
// then holds that count as the conversion result. If the ramp reaches full
// scale with no trip, the block reports an overflow instead. The register
// block downstream reads `count`, `valid` and `overflow`. The CTRL run bit
// drives `run`.
//
// Parameters:
//   WIDTH        counter / result width
//   SYNC_STAGES  comparator synchronizer depth (>= 2)
//   FILTER       consecutive synchronized high samples needed to trip (>= 1)
//
// Ports:
//   clk       in   system clock
//   nreset    in   synchronous, active-low reset
//   run       in   level; 1 lets a conversion run, 0 returns to IDLE
//   comp_in   in   asynchronous comparator output (high = ramp above input)
//   ramp_rst  out  high holds the ramp capacitor discharged
//   busy      out  high while a conversion is in progress
//   count     out  captured conversion result
//   valid     out  `count` holds a completed result
//   overflow  out  ramp reached full scale without a trip
//
// Build option:
//   RAMP_SAMP_LATENCY_COMP_EN  when defined, a DONE result is corrected for
//                              the SYNC_STAGES+FILTER trip latency. The
//                              correction saturates at 0. When the macro is
//                              not defined, the raw counter is captured.
// -----------------------------------------------------------------------------
module ramp_samp_adc #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             run,
  input  logic             comp_in,
  output logic             ramp_rst,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             valid,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_OVF  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  state_t                 state_reg;
  logic [WIDTH-1:0]       counter_reg;
  logic [WIDTH-1:0]       count_reg;
  logic                   valid_reg;
  logic                   overflow_reg;
  logic                   ramp_rst_reg;
  logic                   busy_reg;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [FILTER-1:0]      hist_reg;
  logic [FILTER-1:0]      hist_next;

  logic                   sync_out;
  logic                   trip;
  logic [WIDTH-1:0]       capture_value;

  // ---------------------------------------------------------------------------
  // Comparator synchronizer. It runs in every state, so a comparator that is
  // already high when `run` rises is seen from the first RUN cycle.
  // ---------------------------------------------------------------------------
  assign sync_next[0] = comp_in;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Glitch filter history. A new sample enters bit 0. The trip fires only
  // when the whole window is high.
  // ---------------------------------------------------------------------------
  assign hist_next[0] = sync_out;
  generate
    for (genvar gi = 1; gi < FILTER; gi++) begin : g_hist
      assign hist_next[gi] = hist_reg[gi-1];
    end
  endgenerate

  assign trip = &hist_reg;

  // ---------------------------------------------------------------------------
  // Result selection for a comparator trip.
  // ---------------------------------------------------------------------------
`ifdef RAMP_SAMP_LATENCY_COMP_EN
  // The trip is seen SYNC_STAGES+FILTER cycles after the comparator actually
  // crossed. Back that delay out. Clamp at 0 for early trips.
  localparam int               LATENCY   = SYNC_STAGES + FILTER;
  localparam logic [WIDTH-1:0] LATENCY_W = WIDTH'(LATENCY);

  assign capture_value = (counter_reg >= LATENCY_W) ? (counter_reg - LATENCY_W)
                                                    : '0;
`else
  assign capture_value = counter_reg;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM. All outputs are registered. Dropping `run` in any active
  // state returns every output to its reset value on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg    <= ST_IDLE;
      counter_reg  <= '0;
      hist_reg     <= '0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      ramp_rst_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          counter_reg  <= '0;
          hist_reg     <= '0;
          count_reg    <= '0;
          valid_reg    <= 1'b0;
          overflow_reg <= 1'b0;
          if (run) begin
            // The counter is already 0, so the first RUN cycle counts as 0.
            state_reg    <= ST_RUN;
            ramp_rst_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end else begin
            ramp_rst_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!run) begin
            // Abort: the partial conversion is discarded.
            state_reg    <= ST_IDLE;
            counter_reg  <= '0;
            hist_reg     <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            ramp_rst_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            hist_reg <= hist_next;
            if (trip) begin
              // Test the trip first. That way a trip on the full-scale
              // cycle still counts as a real result, not an overflow.
              state_reg    <= ST_DONE;
              count_reg    <= capture_value;
              valid_reg    <= 1'b1;
              overflow_reg <= 1'b0;
              ramp_rst_reg <= 1'b1;
              busy_reg     <= 1'b0;
            end else if (counter_reg == MAX_COUNT) begin
              state_reg    <= ST_OVF;
              count_reg    <= MAX_COUNT;
              valid_reg    <= 1'b1;
              overflow_reg <= 1'b1;
              ramp_rst_reg <= 1'b1;
              busy_reg     <= 1'b0;
            end else begin
              // Never wraps: the full-scale case above leaves RUN first.
              counter_reg <= counter_reg + WIDTH'(1);
            end
          end
        end

        ST_DONE, ST_OVF: begin
          // Hold the result until `run` drops. A fresh conversion needs
          // `run` to pass through 0 first.
          if (!run) begin
            state_reg    <= ST_IDLE;
            counter_reg  <= '0;
            hist_reg     <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            ramp_rst_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          counter_reg  <= '0;
          hist_reg     <= '0;
          count_reg    <= '0;
          valid_reg    <= 1'b0;
          overflow_reg <= 1'b0;
          ramp_rst_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign ramp_rst = ramp_rst_reg;
  assign busy     = busy_reg;
  assign count    = count_reg;
  assign valid    = valid_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_ramp_samp_adc.sv
// -----------------------------------------------------------------------------
// tb_ramp_samp_adc
// -----------------------------------------------------------------------------
// Directed testbench for ramp_samp_adc with the default parameters
// (WIDTH=8, SYNC_STAGES=2, FILTER=2). Inputs change 1 time unit after a
// rising edge. Outputs are sampled at that same point.
//
// Timing reference used throughout: once start_run returns, the DUT is in
// the counter=0 cycle. Each advance(1) after that moves one counter value
// forward. If comp_in is set during the counter=N cycle, the edge ending N
// samples it. The trip is then captured at the edge ending N+4.
//
// The status vector compared below is {ramp_rst, busy, valid, overflow}.
// -----------------------------------------------------------------------------
module tb_ramp_samp_adc;

  logic       clk;
  logic       nreset;
  logic       run;
  logic       comp_in;
  logic       ramp_rst;
  logic       busy;
  logic [7:0] count;
  logic       valid;
  logic       overflow;

  int errors = 0;
  int checks = 0;

`ifdef RAMP_SAMP_LATENCY_COMP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  ramp_samp_adc #(.WIDTH(8), .SYNC_STAGES(2), .FILTER(2)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .run      (run),
    .comp_in  (comp_in),
    .ramp_rst (ramp_rst),
    .busy     (busy),
    .count    (count),
    .valid    (valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise run. One edge later, the DUT sits in the counter=0 cycle.
  task automatic start_run();
    run = 1'b1;
    advance(1);
  endtask

  task automatic go_idle();
    run     = 1'b0;
    comp_in = 1'b0;
    advance(4);
  endtask

  task automatic test_reset();
    nreset  = 1'b0;
    run     = 1'b1;
    comp_in = 1'b1;
    advance(3);
    checks++;
    if ({ramp_rst, busy, valid, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_status: got %b expected %b", {ramp_rst, busy, valid, overflow}, 4'b1000);
    end
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected %0d", count, 0);
    end
    nreset = 1'b1;
    go_idle();
    $display("reset: status=%b count=%0d", {ramp_rst, busy, valid, overflow}, count);
  endtask

  task automatic test_normal_trip();
    start_run();
    checks++;
    if ({ramp_rst, busy, valid, overflow} !== 4'b0100) begin
      errors++;
      $display("FAIL run_entry_status: got %b expected %b", {ramp_rst, busy, valid, overflow}, 4'b0100);
    end
    advance(10);
    comp_in = 1'b1;
    advance(4);
    checks++;
    if ({ramp_rst, busy, valid, overflow} !== 4'b0100) begin
      errors++;
      $display("FAIL trip_latency_early: got %b expected %b", {ramp_rst, busy, valid, overflow}, 4'b0100);
    end
    advance(1);
    checks++;
    if ({ramp_rst, busy, valid, overflow} !== 4'b1010) begin
      errors++;
      $display("FAIL trip_status: got %b expected %b", {ramp_rst, busy, valid, overflow}, 4'b1010);
    end
    checks++;
    if (count !== 8'(14 - LAT)) begin
      errors++;
      $display("FAIL trip_count: got %0d expected %0d", count, 14 - LAT);
    end
    // Run stays high past DONE. The result must hold, with no restart.
    advance(10);
    checks++;
    if ({ramp_rst, busy, valid, overflow, count} !== {4'b1010, 8'(14 - LAT)}) begin
      errors++;
      $display("FAIL done_hold: got status=%b count=%0d expected status=1010 count=%0d",
               {ramp_rst, busy, valid, overflow}, count, 14 - LAT);
    end
    $display("normal_trip: count=%0d valid=%b overflow=%b", count, valid, overflow);
    go_idle();
  endtask

  task automatic test_comp_high_before_start();
    comp_in = 1'b1;
    advance(4);
    start_run();
    advance(2);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL early_comp_not_yet: got valid=%b expected %b", valid, 1'b0);
    end
    advance(1);
    checks++;
    if ({valid, count} !== {1'b1, 8'(LAT == 0 ? 2 : 0)}) begin
      errors++;
      $display("FAIL early_comp_count: got valid=%b count=%0d expected valid=1 count=%0d",
               valid, count, (LAT == 0 ? 2 : 0));
    end
    $display("comp_high_before_start: count=%0d valid=%b", count, valid);
    go_idle();
  endtask

  task automatic test_glitch();
    start_run();
    advance(20);
    comp_in = 1'b1;
    advance(1);
    comp_in = 1'b0;
    advance(19);
    checks++;
    if ({busy, valid} !== 2'b10) begin
      errors++;
      $display("FAIL glitch_ignored: got busy,valid=%b expected %b", {busy, valid}, 2'b10);
    end
    comp_in = 1'b1;
    advance(5);
    checks++;
    if ({valid, overflow, count} !== {2'b10, 8'(44 - LAT)}) begin
      errors++;
      $display("FAIL glitch_count: got valid=%b ovf=%b count=%0d expected valid=1 ovf=0 count=%0d",
               valid, overflow, count, 44 - LAT);
    end
    $display("glitch: count=%0d valid=%b", count, valid);
    go_idle();
  endtask

  task automatic test_overflow();
    start_run();
    advance(255);
    checks++;
    if ({ramp_rst, busy, valid, overflow} !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_at_max: got %b expected %b", {ramp_rst, busy, valid, overflow}, 4'b0100);
    end
    advance(1);
    checks++;
    if ({ramp_rst, busy, valid, overflow, count} !== {4'b1011, 8'd255}) begin
      errors++;
      $display("FAIL ovf_result: got status=%b count=%0d expected status=1011 count=255",
               {ramp_rst, busy, valid, overflow}, count);
    end
    advance(5);
    checks++;
    if ({busy, valid, overflow, count} !== {3'b011, 8'd255}) begin
      errors++;
      $display("FAIL ovf_hold: got busy,valid,ovf=%b count=%0d expected 011 count=255",
               {busy, valid, overflow}, count);
    end
    $display("overflow: count=%0d overflow=%b", count, overflow);
    go_idle();
  endtask

  task automatic test_trip_at_max();
    start_run();
    advance(251);
    comp_in = 1'b1;
    advance(5);
    checks++;
    if ({ramp_rst, busy, valid, overflow, count} !== {4'b1010, 8'(255 - LAT)}) begin
      errors++;
      $display("FAIL trip_at_max: got status=%b count=%0d expected status=1010 count=%0d",
               {ramp_rst, busy, valid, overflow}, count, 255 - LAT);
    end
    $display("trip_at_max: count=%0d overflow=%b", count, overflow);
    go_idle();
  endtask

  task automatic test_abort_restart();
    start_run();
    advance(30);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: got %b expected %b", busy, 1'b1);
    end
    run = 1'b0;
    advance(1);
    checks++;
    if ({ramp_rst, busy, valid, overflow, count} !== {4'b1000, 8'd0}) begin
      errors++;
      $display("FAIL abort_idle: got status=%b count=%0d expected status=1000 count=0",
               {ramp_rst, busy, valid, overflow}, count);
    end
    advance(3);
    // Restart: the counter must start again from 0.
    start_run();
    advance(5);
    comp_in = 1'b1;
    advance(5);
    checks++;
    if ({valid, count} !== {1'b1, 8'(9 - LAT)}) begin
      errors++;
      $display("FAIL restart_count: got valid=%b count=%0d expected valid=1 count=%0d",
               valid, count, 9 - LAT);
    end
    $display("abort_restart: count=%0d valid=%b", count, valid);
    go_idle();
  endtask

  task automatic test_reset_midrun();
    start_run();
    advance(7);
    nreset = 1'b0;
    advance(1);
    checks++;
    if ({ramp_rst, busy, valid, overflow, count} !== {4'b1000, 8'd0}) begin
      errors++;
      $display("FAIL reset_midrun: got status=%b count=%0d expected status=1000 count=0",
               {ramp_rst, busy, valid, overflow}, count);
    end
    nreset = 1'b1;
    $display("reset_midrun: status=%b", {ramp_rst, busy, valid, overflow});
    go_idle();
  endtask

  initial begin
    nreset  = 1'b0;
    run     = 1'b0;
    comp_in = 1'b0;
    test_reset();
    test_normal_trip();
    test_comp_high_before_start();
    test_glitch();
    test_overflow();
    test_trip_at_max();
    test_abort_restart();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ramp_samp_adc.md
# ramp_samp_adc

Single-channel ramp-and-sample ADC sequencer. Counts clock cycles from ramp release until the analog comparator trips, then holds the count as the conversion result. It sits directly upstream of the wishbone register block: `run` is driven by CTRL_reg bit31 (run_ramp_Nreset_counters), and `count`/`valid`/`overflow` feed the low byte of ramp_samp_count0 or ramp_samp_count1. Two instances are used, one per ADC channel.

## Interface
Parameters:
- `WIDTH` = 8: counter and result width (WIDTH_RAMP_AND_SAMP).
- `SYNC_STAGES` = 2: comparator synchronizer depth, ≥2.
- `FILTER` = 2: consecutive synchronized high samples required to accept a trip, ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock (wb_clk_i).
- `nreset` in 1: synchronous, active-low reset.
- `run` in 1: level input. 1 lets the conversion run; 0 resets the sequencer.
- `comp_in` in 1: asynchronous analog comparator output. High means the ramp is above the input.
- `ramp_rst` out 1: high holds the ramp capacitor discharged.
- `busy` out 1: high while a conversion is in progress.
- `count` out WIDTH: captured conversion result.
- `valid` out 1: `count` holds a completed result.
- `overflow` out 1: the ramp reached full scale without a trip.

## Operation
- **Synchronizer:** `comp_in` passes through `SYNC_STAGES` flops every cycle, in all states. The synchronizer is cleared only by `nreset`.
- **Filter:** a `FILTER`-bit history shifts in the synchronized sample at the end of each RUN cycle. It is cleared in IDLE.
  - `trip` = all `FILTER` history bits are 1.
  - Pulses shorter than `FILTER` synchronized cycles are ignored.
- **States:**
  - IDLE: `ramp_rst`=1, `busy`=0, counter=0, `count`=0, `valid`=0, `overflow`=0.
    - `run`=1 → RUN.
  - RUN: `ramp_rst`=0, `busy`=1. On its first cycle the counter is 0; it increments by 1 each RUN cycle.
    - `trip` → DONE: `count` ← counter, `valid`=1.
    - Otherwise, counter == 2^WIDTH−1 → OVF: `count` ← 2^WIDTH−1, `valid`=1, `overflow`=1.
    - If `trip` occurs on the max-count cycle, `trip` wins: DONE with `count`=max and `overflow`=0.
  - DONE / OVF: `ramp_rst`=1, `busy`=0. `count`, `valid` and `overflow` are held stable.
- **Leaving any state:** `run`=0 in RUN, DONE or OVF → IDLE on the next edge.
  - Dropping `run` mid-RUN discards the conversion: `valid` stays 0.
- **Restart:** a new conversion needs `run` to spend at least one cycle at 0. DONE and OVF never restart while `run` stays 1.
- **Arithmetic:** the counter is unsigned, WIDTH bits, and never wraps.

## Timing
- Reset values: state IDLE, `ramp_rst`=1, `busy`=0, `count`=0, `valid`=0, `overflow`=0, counter=0, filter history=0, synchronizer=0.
- `run` 0→1 sampled at edge E: RUN from E, `ramp_rst` falls after E.
- Trip latency is `SYNC_STAGES`+`FILTER` cycles.
  - Example: `comp_in` is first sampled high at the edge ending counter=N.
  - `trip` is then true during counter=N+`SYNC_STAGES`+`FILTER`.
  - That value is captured at the edge ending that cycle, and `valid` rises at that same edge.
- `count`, `valid` and `overflow` change in the same cycle as one another.
- `run` 1→0 sampled at edge F: IDLE after F, and all outputs return to their reset values.
- `nreset` low at any edge forces reset values after that edge, regardless of `run`.

## Configuration
- `RAMP_SAMP_LATENCY_COMP_EN` defined: the captured value in DONE is counter − (`SYNC_STAGES`+`FILTER`), saturating at 0.
  - The OVF value stays 2^WIDTH−1.
  - Trip on the max-count cycle yields max − (`SYNC_STAGES`+`FILTER`).
- Not defined: the raw counter value is captured. No subtractor is synthesized.

## Test plan
Defaults throughout: WIDTH=8, SYNC_STAGES=2, FILTER=2.
- **Reset:** `nreset`=0 for 3 cycles with `run`=1 and `comp_in`=1 → `ramp_rst`=1, `busy`=0, `count`=0, `valid`=0, `overflow`=0.
- **Normal trip:** `run`=1; `comp_in` first sampled high at the edge ending counter=10.
  - Macro undefined → `count`=14, `valid`=1, `overflow`=0, `ramp_rst`=1.
  - Macro defined → `count`=10.
- **Comparator high before start:** `comp_in`=1 before `run` rises → `count`=2 with the macro undefined, `count`=0 with it defined.
- **Glitch rejection:** a 1-cycle `comp_in` pulse at counter=20, then a steady high from counter=40 → `count`=44 (macro undefined); the glitch is ignored.
- **Overflow:** `comp_in`=0 throughout → after 256 RUN cycles, `count`=255, `valid`=1, `overflow`=1.
  - Separate case: steady trip timed to land on counter=255 → DONE with `overflow`=0.
- **Abort and restart:** drop `run` at counter=30 → IDLE with `valid`=0 and `count`=0.
  - Hold `run` high past DONE → no restart.
  - Cycle `run` 0→1 → the counter restarts at 0.
